// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite attribute store and the EX stage:
// geometry, lane codes, sprite-action lane mapping and the clear FSM states.
package sprite_pkg;

    localparam int DEF_NUM_SPRITES = 256;
    localparam int LANES           = 8;
    localparam int IDX_W           = 8;
    localparam int LANE_W          = 3;
    localparam int ADDR_W          = IDX_W + LANE_W;

    localparam logic [LANE_W-1:0] LANE_DATA  = 3'd0;
    localparam logic [LANE_W-1:0] LANE_ATTR1 = 3'd1;
    localparam logic [LANE_W-1:0] LANE_ATTR2 = 3'd2;
    localparam logic [LANE_W-1:0] LANE_ATTR3 = 3'd3;
    localparam logic [LANE_W-1:0] LANE_ATTR4 = 3'd4;
    localparam logic [LANE_W-1:0] LANE_ATTR5 = 3'd5;
    localparam logic [LANE_W-1:0] LANE_ATTR6 = 3'd6;
    localparam logic [LANE_W-1:0] LANE_ATTR7 = 3'd7;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Maps an EX sprite action code onto the attribute lane it touches.
    function automatic logic [LANE_W-1:0] action_to_lane(input logic [3:0] action);
        case (action)
            4'b1000: return LANE_ATTR1;
            4'b1001: return LANE_ATTR2;
            4'b0011: return LANE_ATTR4;
            4'b0111: return LANE_ATTR5;
            4'b0000: return LANE_ATTR6;
            4'b0010: return LANE_ATTR7;
            default: return LANE_DATA;
        endcase
    endfunction

    // True when a sprite index addresses a populated entry.
    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx, input int num_sprites);
        return (int'(idx) < num_sprites);
    endfunction

endpackage

// File: rtl/sprite_mem_unit_if.sv
// Byte (EX) and full-sprite (loader/renderer) access bus of the sprite store.
interface sprite_mem_unit_if;
    import sprite_pkg::*;

    logic              clr_req;
    logic [ADDR_W-1:0] byte_addr;
    logic [7:0]        byte_wdata;
    logic              byte_re;
    logic              byte_we;
    logic [31:0]       byte_rdata;
    logic              byte_rvalid;
    logic [IDX_W-1:0]  full_addr;
    logic [63:0]       full_wdata;
    logic              full_we;
    logic              full_re;
    logic [63:0]       full_rdata;
    logic              full_rvalid;
    logic              busy;

    modport master (
        output clr_req, byte_addr, byte_wdata, byte_re, byte_we,
               full_addr, full_wdata, full_we, full_re,
        input  byte_rdata, byte_rvalid, full_rdata, full_rvalid, busy
    );

    modport slave (
        input  clr_req, byte_addr, byte_wdata, byte_re, byte_we,
               full_addr, full_wdata, full_we, full_re,
        output byte_rdata, byte_rvalid, full_rdata, full_rvalid, busy
    );

endinterface

// File: rtl/sprite_mem_array.sv
// Eight byte-lane banks with two write ports (A then B, B wins a shared lane)
// and two registered 64-bit read ports with write-first bypass.
module sprite_mem_array
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = DEF_NUM_SPRITES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LANES-1:0]  wa_we,
    input  logic [IDX_W-1:0]  wa_addr,
    input  logic [63:0]       wa_wdata,
    input  logic [LANES-1:0]  wb_we,
    input  logic [IDX_W-1:0]  wb_addr,
    input  logic [7:0]        wb_wdata,
    input  logic              ra_re,
    input  logic [IDX_W-1:0]  ra_addr,
    output logic [63:0]       ra_rdata,
    input  logic              rb_re,
    input  logic [IDX_W-1:0]  rb_addr,
    output logic [63:0]       rb_rdata
);

    logic        wa_ok_s;
    logic        wb_ok_s;
    logic [63:0] ra_merged_s;
    logic [63:0] rb_merged_s;
    logic [63:0] ra_rdata_d;
    logic [63:0] ra_rdata_q;
    logic [63:0] rb_rdata_d;
    logic [63:0] rb_rdata_q;

    assign wa_ok_s = idx_in_range(wa_addr, NUM_SPRITES);
    assign wb_ok_s = idx_in_range(wb_addr, NUM_SPRITES);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] bank [NUM_SPRITES];

        // Commit lane writes; port B is assigned last so it wins a same-entry collision.
        always_ff @(posedge clk) begin
            if (wa_we[l] && wa_ok_s) begin
                bank[wa_addr] <= wa_wdata[8*l +: 8];
            end
            if (wb_we[l] && wb_ok_s) begin
                bank[wb_addr] <= wb_wdata;
            end
        end

        assign ra_merged_s[8*l +: 8] =
            (wb_we[l] && wb_ok_s && (wb_addr == ra_addr)) ? wb_wdata :
            (wa_we[l] && wa_ok_s && (wa_addr == ra_addr)) ? wa_wdata[8*l +: 8] :
            bank[ra_addr];
        assign rb_merged_s[8*l +: 8] =
            (wb_we[l] && wb_ok_s && (wb_addr == rb_addr)) ? wb_wdata :
            (wa_we[l] && wa_ok_s && (wa_addr == rb_addr)) ? wa_wdata[8*l +: 8] :
            bank[rb_addr];
    end

    // Capture bypassed read data on a read strobe, zero for absent entries, else hold.
    always_comb begin
        if (ra_re) begin
            ra_rdata_d = idx_in_range(ra_addr, NUM_SPRITES) ? ra_merged_s : 64'h0;
        end else begin
            ra_rdata_d = ra_rdata_q;
        end
        if (rb_re) begin
            rb_rdata_d = idx_in_range(rb_addr, NUM_SPRITES) ? rb_merged_s : 64'h0;
        end else begin
            rb_rdata_d = rb_rdata_q;
        end
    end

    // Read data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_rdata_q <= 64'h0;
            rb_rdata_q <= 64'h0;
        end else begin
            ra_rdata_q <= ra_rdata_d;
            rb_rdata_q <= rb_rdata_d;
        end
    end

    assign ra_rdata = ra_rdata_q;
    assign rb_rdata = rb_rdata_q;

endmodule

// File: rtl/sprite_mem_unit.sv
// Sprite attribute store behind EX: clear FSM, write-enable merge of the
// byte and full ports, and byte-lane selection of the byte read.
module sprite_mem_unit
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = DEF_NUM_SPRITES
) (
    input  logic               clk,
    input  logic               rst_n,
    sprite_mem_unit_if.slave   bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    state_e            state_d, state_q;
    logic [IDX_W-1:0]  cnt_d, cnt_q;
    logic              busy_d, busy_q;
    logic              byte_rvalid_d, byte_rvalid_q;
    logic              full_rvalid_d, full_rvalid_q;
    logic [LANE_W-1:0] lane_d, lane_q;

    logic [IDX_W-1:0]  byte_idx_s;
    logic [LANE_W-1:0] byte_lane_s;
    logic              byte_wr_s, byte_rd_s, full_wr_s, full_rd_s;
    logic [LANES-1:0]  wa_we_s, wb_we_s;
    logic [IDX_W-1:0]  wa_addr_s;
    logic [63:0]       wa_wdata_s;
    logic [63:0]       full_rdata_s, byte_row_s;

    assign byte_idx_s  = bus.byte_addr[ADDR_W-1:LANE_W];
    assign byte_lane_s = bus.byte_addr[LANE_W-1:0];
    assign byte_wr_s   = bus.byte_we & ~busy_q;
    assign byte_rd_s   = bus.byte_re & ~busy_q;
    assign full_wr_s   = bus.full_we & ~busy_q;
    assign full_rd_s   = bus.full_re & ~busy_q;

    // Port A carries the clear sweep while busy, otherwise the full-entry write;
    // port B carries the single-lane byte write.
    always_comb begin
        if (busy_q) begin
            wa_we_s    = {LANES{1'b1}};
            wa_addr_s  = cnt_q;
            wa_wdata_s = 64'h0;
        end else begin
            wa_we_s    = {LANES{full_wr_s}};
            wa_addr_s  = bus.full_addr;
            wa_wdata_s = bus.full_wdata;
        end
        if (byte_wr_s) begin
            wb_we_s = 8'b0000_0001 << byte_lane_s;
        end else begin
            wb_we_s = 8'b0000_0000;
        end
    end

    // Clear FSM next state, read-valid pulses and remembered byte lane.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (bus.clr_req) begin
                    cnt_d = {IDX_W{1'b0}};
                end else if (cnt_q == LAST_IDX) begin
                    state_d = READY;
                    cnt_d   = {IDX_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            READY: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = {IDX_W{1'b0}};
            end
        endcase
        busy_d        = (state_d == CLEAR);
        byte_rvalid_d = byte_rd_s;
        full_rvalid_d = full_rd_s;
        lane_d        = byte_rd_s ? byte_lane_s : lane_q;
    end

    // State and output registers; reset restarts the clear from entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CLEAR;
            cnt_q         <= {IDX_W{1'b0}};
            busy_q        <= 1'b1;
            byte_rvalid_q <= 1'b0;
            full_rvalid_q <= 1'b0;
            lane_q        <= LANE_DATA;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            byte_rvalid_q <= byte_rvalid_d;
            full_rvalid_q <= full_rvalid_d;
            lane_q        <= lane_d;
        end
    end

    sprite_mem_array #(
        .NUM_SPRITES (NUM_SPRITES)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .wa_we    (wa_we_s),
        .wa_addr  (wa_addr_s),
        .wa_wdata (wa_wdata_s),
        .wb_we    (wb_we_s),
        .wb_addr  (byte_idx_s),
        .wb_wdata (bus.byte_wdata),
        .ra_re    (full_rd_s),
        .ra_addr  (bus.full_addr),
        .ra_rdata (full_rdata_s),
        .rb_re    (byte_rd_s),
        .rb_addr  (byte_idx_s),
        .rb_rdata (byte_row_s)
    );

    assign bus.full_rdata  = full_rdata_s;
    assign bus.full_rvalid = full_rvalid_q;
    assign bus.byte_rdata  = {24'h0, byte_row_s[{lane_q, 3'b000} +: 8]};
    assign bus.byte_rvalid = byte_rvalid_q;
    assign bus.busy        = busy_q;

endmodule
